// File: rtl/hqm_aw_tx_sync_arb.sv
// Round-robin arbiter feeding NUM_REQ requesters into a 2-entry in-order FIFO,
// with a reset-preparation sequence that stops granting, drains the FIFO and halts.
module hqm_aw_tx_sync_arb #(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int SIDX    = $clog2(NUM_REQ)
) (
    input  logic                     hqm_gated_clk,
    input  logic                     hqm_gated_rst,
    input  logic                     rst_prep,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SIDX-1:0]          out_src,
    output logic                     idle,
    output logic [6:0]               status
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    typedef struct packed {
        logic [SIDX-1:0]  src;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_t          state, next_state;
    entry_t          fifo [2];
    entry_t          new_entry;
    logic [1:0]      occ;
    logic [SIDX-1:0] rr_ptr, winner, scan_idx;
    logic [2:0]      last_grant;
    logic            any_valid, can_push, push, pop;

    // NOTE: blocking assignments in combinational logic; scanning from the top
    // down lets the lowest offset from rr_ptr be the last (winning) write.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = SIDX'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[scan_idx]) begin
                winner    = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    // rst_prep and reset gate grants combinationally, so no grant leaks in the cycle they rise.
    assign can_push  = (state == ST_RUN) && !rst_prep && !hqm_gated_rst && (occ != 2'd2);
    assign push      = can_push && any_valid;
    assign pop       = out_valid && out_ready;
    assign new_entry = {winner, req_data[int'(winner)*WIDTH +: WIDTH]};

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        req_ready = '0;
        if (push) req_ready[winner] = 1'b1;
    end

    // NOTE: the two storage entries are reset too, so out_data/out_src read zero
    // while reset is held; sequential state uses non-blocking assignments only.
    always_ff @(posedge hqm_gated_clk or posedge hqm_gated_rst) begin
        if (hqm_gated_rst) begin
            fifo[0]    <= '0;
            fifo[1]    <= '0;
            occ        <= '0;
            rr_ptr     <= '0;
            last_grant <= '0;
        end else begin
            if (pop) fifo[0] <= fifo[1];
            if (push) begin
                // Land in the slot that will be the tail after this cycle's pop.
                if (occ == 2'd0 || (occ == 2'd1 && pop)) fifo[0] <= new_entry;
                else                                      fifo[1] <= new_entry;
                rr_ptr     <= SIDX'((int'(winner) + 1) % NUM_REQ);
                last_grant <= 3'(winner);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge hqm_gated_clk or posedge hqm_gated_rst) begin
        if (hqm_gated_rst) state <= ST_RUN;
        else               state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (rst_prep) next_state = ST_DRAIN;
            ST_DRAIN: begin
                if (!rst_prep)                                next_state = ST_RUN;
                else if (occ == 2'd0 || (occ == 2'd1 && pop)) next_state = ST_HALT;
            end
            ST_HALT:  if (!rst_prep) next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = fifo[0].data;
    assign out_src   = fifo[0].src;
    assign idle      = (state == ST_HALT) ||
                       ((state == ST_RUN) && (occ == 2'd0) && (req_valid == '0));
    assign status    = {last_grant, state == ST_HALT, state == ST_DRAIN, occ};

endmodule

// File: tb/tb_hqm_aw_tx_sync_arb.sv
// Bench for hqm_aw_tx_sync_arb: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_hqm_aw_tx_sync_arb;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         rst_prep  = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data  = '0;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         idle;
    logic [6:0]   status;

    int n_vec = 0;
    int n_bad = 0;

    hqm_aw_tx_sync_arb #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .hqm_gated_clk (clk),
        .hqm_gated_rst (rst),
        .rst_prep      (rst_prep),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_src       (out_src),
        .idle          (idle),
        .status        (status)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of accepted beats, a pointer and a mode.
    typedef struct {
        int          src;
        logic [31:0] data;
    } beat_t;

    beat_t q[$];
    int    m_rr   = 0;
    int    m_last = 0;
    int    m_mode = M_RUN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner(input logic [3:0] v, input int rr);
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [1:0] j;
            j = 2'((rr + k) % NUM_REQ);
            if (v[j]) return int'(j);
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready_exp();
        int w;
        w = m_winner(req_valid, m_rr);
        if (rst || m_mode != M_RUN || rst_prep || q.size() >= 2 || w < 0) return 4'b0000;
        return 4'(1) << w;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int         w;
        logic [3:0] rdy;
        if (rst) begin
            q.delete();
            m_rr   = 0;
            m_last = 0;
            m_mode = M_RUN;
        end else begin
            w   = m_winner(req_valid, m_rr);
            rdy = m_ready_exp();
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (rdy != 4'b0000) begin
                q.push_back('{src: w, data: req_data[w*32 +: 32]});
                m_rr   = (w + 1) % NUM_REQ;
                m_last = w;
            end
            case (m_mode)
                M_RUN:   if (rst_prep) m_mode = M_DRAIN;
                M_DRAIN: if (!rst_prep) m_mode = M_RUN;
                         else if (q.size() == 0) m_mode = M_HALT;
                M_HALT:  if (!rst_prep) m_mode = M_RUN;
                default: m_mode = M_RUN;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        int   sz;
        logic exp_idle;
        sz       = q.size();
        exp_idle = (m_mode == M_HALT) || (m_mode == M_RUN && sz == 0 && req_valid == 4'b0000);
        check("req_ready", req_ready, m_ready_exp());
        check("out_valid", out_valid, sz != 0);
        if (sz != 0) begin
            check("out_data", out_data, q[0].data);
            check("out_src", out_src, q[0].src);
        end
        check("idle", idle, exp_idle);
        check("status", status, {m_last[2:0], m_mode == M_HALT, m_mode == M_DRAIN, sz[1:0]});
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*32 +: 32] = d;
    endtask

    int fair_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        // Reset: ready gated even with every requester valid.
        req_valid = 4'hF;
        repeat (2) next_cyc();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_status", status, 7'd0);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_out_data", out_data, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Fairness: all valid, grants rotate, out_src trails by one cycle.
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < NUM_REQ; r++) set_data(r, $urandom);
            #2;
            check("fair_grant", req_ready, 4'(1) << fair_seq[i]);
            if (i > 0) check("fair_src", out_src, fair_seq[i-1]);
            next_cyc();
        end
        req_valid = 4'b0000;
        repeat (2) next_cyc();

        // Skip/wrap: bring rr_ptr to 3, then 4'b0101 grants 0 then 2.
        req_valid = 4'b0100;
        #2 check("wrap_pre", req_ready, 4'b0100);
        next_cyc();
        req_valid = 4'b0101;
        #2 check("wrap_g0", req_ready, 4'b0001);
        next_cyc();
        #2 check("wrap_g2", req_ready, 4'b0100);
        next_cyc();
        req_valid = 4'b1111;
        #2 check("wrap_ptr", req_ready, 4'b1000);
        check("wrap_last", status[6:4], 3'd2);
        req_valid = 4'b0000;
        repeat (3) next_cyc();

        // Backpressure: A and B fill the FIFO, C waits, stall keeps A stable.
        out_ready = 1'b0;
        req_valid = 4'b0010;
        set_data(1, 32'hAAAA_0001);
        #2 check("bp_acc_a", req_ready, 4'b0010);
        next_cyc();
        set_data(1, 32'hBBBB_0002);
        #2 check("bp_acc_b", req_ready, 4'b0010);
        next_cyc();
        set_data(1, 32'hCCCC_0003);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp_full", req_ready, 4'b0000);
            check("bp_occ", status[1:0], 2'd2);
            check("bp_hold", out_data, 32'hAAAA_0001);
            next_cyc();
        end
        out_ready = 1'b1;
        #2 check("bp_pop_a", out_data, 32'hAAAA_0001);
        next_cyc();
        #2 check("bp_pop_b", out_data, 32'hBBBB_0002);
        check("bp_acc_c", req_ready, 4'b0010);
        next_cyc();
        req_valid = 4'b0000;
        #2 check("bp_pop_c", out_data, 32'hCCCC_0003);
        check("bp_occ_c", status[1:0], 2'd1);
        repeat (2) next_cyc();

        // Drain: full FIFO, rst_prep with out_ready=1 empties it and halts.
        out_ready = 1'b0;
        req_valid = 4'b0001;
        set_data(0, 32'hD000_0000);
        next_cyc();
        set_data(0, 32'hD000_0001);
        next_cyc();
        rst_prep  = 1'b1;
        out_ready = 1'b1;
        #2 check("drn_block", req_ready, 4'b0000);
        check("drn_occ2", status[1:0], 2'd2);
        next_cyc();
        #2 check("drn_state", status[3:2], 2'b01);
        check("drn_data", out_data, 32'hD000_0001);
        next_cyc();
        #2 check("drn_halt", status[3:2], 2'b10);
        check("drn_idle", idle, 1'b1);
        check("drn_ov", out_valid, 1'b0);
        next_cyc();
        rst_prep = 1'b0;
        #2 check("drn_still_halt", status[3], 1'b1);
        next_cyc();
        #2 check("drn_run", status[3:2], 2'b00);
        check("drn_resume", req_ready, 4'b0001);
        req_valid = 4'b0000;
        repeat (2) next_cyc();

        // Drain abort: one-cycle rst_prep with a full, stalled FIFO.
        out_ready = 1'b0;
        req_valid = 4'b0010;
        set_data(1, 32'hE000_0000);
        next_cyc();
        set_data(1, 32'hE000_0001);
        next_cyc();
        req_valid = 4'b0000;
        rst_prep  = 1'b1;
        #2 check("abt_block", req_ready, 4'b0000);
        next_cyc();
        rst_prep = 1'b0;
        #2 check("abt_drain", status[3:2], 2'b01);
        check("abt_occ", status[1:0], 2'd2);
        next_cyc();
        req_valid = 4'b0100;
        set_data(2, 32'hE000_0002);
        #2 check("abt_run", status[3:2], 2'b00);
        check("abt_full", req_ready, 4'b0000);
        next_cyc();
        out_ready = 1'b1;
        #2 check("abt_head", out_data, 32'hE000_0000);
        next_cyc();
        #2 check("abt_grant", req_ready, 4'b0100);
        check("abt_e1", out_data, 32'hE000_0001);
        next_cyc();
        req_valid = 4'b0000;
        #2 check("abt_e2", out_data, 32'hE000_0002);
        repeat (2) next_cyc();

        // Async reset between edges while streaming.
        req_valid = 4'hF;
        repeat (3) next_cyc();
        #2 rst = 1'b1;
        #1;
        check("ar_ov", out_valid, 1'b0);
        check("ar_status", status, 7'd0);
        check("ar_ready", req_ready, 4'b0000);
        check("ar_data", out_data, 32'd0);
        next_cyc();
        rst       = 1'b0;
        req_valid = 4'b0100;
        #2 check("ar_first", req_ready, 4'b0100);
        check("ar_empty", out_valid, 1'b0);
        next_cyc();
        req_valid = 4'b0000;
        next_cyc();

        // Random traffic with bursty backpressure and rst_prep episodes.
        for (int c = 0; c < 3000; c++) begin
            req_valid = 4'($urandom);
            for (int r = 0; r < NUM_REQ; r++) set_data(r, $urandom);
            out_ready = ($urandom_range(0, 99) < (c[9] ? 30 : 80));
            if ($urandom_range(0, 19) == 0) rst_prep = !rst_prep;
            next_cyc();
        end
        rst_prep  = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        repeat (5) next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hqm_aw_tx_sync_arb.md
HQM_AW_TX_SYNC_ARB -- requirements
Module: hqm_AW_tx_sync_arb

Interface
REQ-001 Parameter WIDTH, default 32: payload bit width per requester and output.
REQ-002 Parameter NUM_REQ, default 4, legal 2..8: number of requesters; SIDX = $clog2(NUM_REQ).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; port names are hqm_gated_clk and hqm_gated_rst.
REQ-004 hqm_gated_clk  in  1  sole clock; all state on rising edge.
REQ-005 hqm_gated_rst  in  1  asynchronous active-high reset.
REQ-006 rst_prep  in  1  reset-preparation request; stop accepting, drain, halt.
REQ-007 req_valid  in  NUM_REQ  per-requester valid.
REQ-008 req_ready  out  NUM_REQ  per-requester ready; at most one bit set.
REQ-009 req_data  in  NUM_REQ*WIDTH  requester i payload at bits [i*WIDTH +: WIDTH].
REQ-010 out_valid  out  1  output beat valid.
REQ-011 out_ready  in  1  downstream ready.
REQ-012 out_data  out  WIDTH  output payload.
REQ-013 out_src  out  SIDX  requester index of the current output beat.
REQ-014 idle  out  1  no held data, no pending requests, not draining.
REQ-015 status  out  7  [1:0] occupancy, [2] DRAIN, [3] HALT, [6:4] last granted index (zero-extended).

Function
REQ-016 Storage SHALL be a 2-entry in-order FIFO; each entry holds {src, data}; occupancy 0..2.
REQ-017 Transfer rules: input transfer on req_valid[i] & req_ready[i]; output transfer on out_valid & out_ready.
REQ-018 Winner SHALL be the first set req_valid bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-019 req_ready SHALL be set only for the winner, and only when state == RUN and occupancy < 2.
- req_ready may depend combinationally on req_valid.
- A requester's valid SHALL NOT be required to depend on its ready.
REQ-020 rr_ptr SHALL update to (winner+1) mod NUM_REQ only on an accepted input transfer; otherwise it holds.
REQ-021 status[6:4] SHALL update to the winner index on an accepted input transfer.
REQ-022 Latency: a beat accepted in cycle N SHALL be presented on out_valid/out_data/out_src at cycle N+1 at the earliest.
REQ-023 out_valid SHALL equal (occupancy != 0); output data SHALL NOT depend on req_* in the same cycle.
REQ-024 Simultaneous push and pop:
- occupancy 1: stays 1, with the new beat at the head next cycle.
- occupancy 2: push is impossible per REQ-019, so occupancy goes to 1.
REQ-025 Output order SHALL equal acceptance order; no beat is dropped or duplicated.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable.
REQ-027 FSM states are RUN, DRAIN, HALT; encoding is free.
REQ-028 FSM transitions:
- RUN & rst_prep -> DRAIN.
- DRAIN & !rst_prep -> RUN.
- DRAIN & rst_prep & occupancy==0, or occupancy reaching 0 via a pop this cycle -> HALT on the next edge.
- HALT & !rst_prep -> RUN.
- All other cases: hold state.
REQ-029 In DRAIN, the FIFO SHALL keep emitting to out_* normally; no grants are issued.
REQ-030 In HALT, out_valid=0 and req_ready=0.
REQ-031 The RUN->DRAIN transition SHALL block grants in the same cycle rst_prep rises; rst_prep is combinational into req_ready.
REQ-032 idle SHALL be 1 in either of these cases, else 0:
- state==HALT;
- state==RUN & occupancy==0 & req_valid==0.

Reset
REQ-033 While hqm_gated_rst=1, the following SHALL hold immediately (asynchronously):
- state=RUN, occupancy=0, rr_ptr=0, status[6:4]=0;
- out_valid=0, out_data=0, out_src=0;
- status reflects these values;
- req_ready=0 (gated while reset is asserted).
REQ-034 Reset asserted mid-transfer SHALL discard FIFO contents; the first cycle after deassertion behaves as a fresh RUN.

Verification
REQ-035 Fairness: NUM_REQ=4, all req_valid=1, out_ready=1 for 8 beats -> grant order 0,1,2,3,0,1,2,3; out_src is the same sequence delayed 1 cycle.
REQ-036 Skip/wrap: rr_ptr=3, req_valid=4'b0101 -> grant 0, then 2; rr_ptr ends at 3.
REQ-037 Backpressure: out_ready=0, req_valid[1]=1 with data A,B,C -> A,B accepted, occupancy=2, req_ready=0, C held.
- Then out_ready=1 -> A, B, C emitted in order, with out_data stable during the stall.
REQ-038 Drain: occupancy=2, assert rst_prep with out_ready=1 -> req_ready=0 the same cycle, 2 beats emitted, then HALT, status[3]=1, idle=1.
- Deassert rst_prep -> RUN next cycle.
REQ-039 Drain abort: rst_prep pulses 1 cycle with occupancy=2, out_ready=0 -> DRAIN then RUN; no data lost, grants resume.
REQ-040 Async reset: assert hqm_gated_rst mid-stream between clock edges -> out_valid=0 and status=0 immediately.
- After release, request 2 is granted first when req_valid=4'b0100.
